// File: rtl/fp_cvt_f2i_pipe.sv
// fp_cvt_f2i_pipe: two-stage binary32 -> integer converter (FCVT.W[U].S, FCVT.L[U].S).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake; in_ready is combinational (pipe can advance)
//   in_float              IEEE-754 binary32 operand
//   in_unsigned           0: signed target, 1: unsigned target
//   in_rm                 rounding mode (RNE/RTZ/RDN/RUP/RMM; reserved codes act as RTZ)
//   in_tag                opaque tag returned with the result
//   out_valid/out_ready   result handshake
//   out_int               converted integer (XLEN bits)
//   out_flags             {NV,DZ,OF,UF,NX}; only NV and NX are produced
//   out_tag               tag of the result
module fp_cvt_f2i_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_float,
    input  logic             in_unsigned,
    input  logic [2:0]       in_rm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_int,
    output logic [4:0]       out_flags,
    output logic [TAG_W-1:0] out_tag
);

    // Both stages move together whenever the output register is free or draining.
    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // ---------------- Stage 1: unpack and align ----------------
    logic [7:0]      w_exp;
    logic [23:0]     w_mant;
    logic [47:0]     w_ext;
    logic [4:0]      w_rshift;
    logic [5:0]      w_lshift;
    logic [XLEN-1:0] w_s1_int;
    logic            w_s1_guard;
    logic            w_s1_sticky;
    logic            w_s1_nan;
    logic            w_s1_ovf;

    assign w_exp  = in_float[30:23];
    assign w_mant = {w_exp != 8'd0, in_float[22:0]};

    // Thresholds are compared on the biased exponent: e = E - 127.
    always_comb begin
        w_ext       = '0;
        w_rshift    = '0;
        w_lshift    = '0;
        w_s1_int    = '0;
        w_s1_guard  = 1'b0;
        w_s1_sticky = 1'b0;
        w_s1_nan    = 1'b0;
        w_s1_ovf    = 1'b0;
        if (w_exp == 8'hFF) begin
            w_s1_nan = (in_float[22:0] != 23'd0);
            w_s1_ovf = (in_float[22:0] == 23'd0);
        end else if (w_exp >= 8'(127 + XLEN)) begin
            w_s1_ovf = 1'b1;
        end else if (w_exp >= 8'd150) begin
            w_lshift = 6'(w_exp - 8'd150);
            w_s1_int = {{(XLEN-24){1'b0}}, w_mant} << w_lshift;
        end else if (w_exp >= 8'd127) begin
            // Shift the significand into a 48-bit window: upper half is the integer
            // part, bit 23 the guard, bits below it feed sticky.
            w_rshift    = 5'(8'd150 - w_exp);
            w_ext       = {w_mant, 24'd0} >> w_rshift;
            w_s1_int    = {{(XLEN-24){1'b0}}, w_ext[47:24]};
            w_s1_guard  = w_ext[23];
            w_s1_sticky = |w_ext[22:0];
        end else begin
            // |x| < 1: guard only for 0.5 <= |x| < 1, everything else is sticky.
            w_s1_guard  = (w_exp == 8'd126);
            w_s1_sticky = (w_mant != 24'd0) && !((w_exp == 8'd126) && (in_float[22:0] == 23'd0));
        end
    end

    logic             r_s1_valid;
    logic             r_s1_sign;
    logic             r_s1_unsigned;
    logic [2:0]       r_s1_rm;
    logic [TAG_W-1:0] r_s1_tag;
    logic [XLEN-1:0]  r_s1_int;
    logic             r_s1_guard;
    logic             r_s1_sticky;
    logic             r_s1_nan;
    logic             r_s1_ovf;

    // ---------------- Stage 2: round, range-check, negate ----------------
    logic            w_inc;
    logic [XLEN:0]   w_mag;
    logic            w_in_range;
    logic [XLEN-1:0] w_max;
    logic [XLEN-1:0] w_min;
    logic [XLEN-1:0] w_s2_int;
    logic [4:0]      w_s2_flags;

    always_comb begin
        unique case (r_s1_rm)
            3'b000:  w_inc = r_s1_guard && (r_s1_sticky || r_s1_int[0]);
            3'b010:  w_inc = r_s1_sign && (r_s1_guard || r_s1_sticky);
            3'b011:  w_inc = !r_s1_sign && (r_s1_guard || r_s1_sticky);
            3'b100:  w_inc = r_s1_guard;
            default: w_inc = 1'b0;  // RTZ and reserved encodings
        endcase
    end

    assign w_mag = {1'b0, r_s1_int} + {{XLEN{1'b0}}, w_inc};

    always_comb begin
        w_max = r_s1_unsigned ? {XLEN{1'b1}} : {1'b0, {(XLEN-1){1'b1}}};
        w_min = r_s1_unsigned ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        if (r_s1_unsigned) begin
            w_in_range = r_s1_sign ? (w_mag == '0) : !w_mag[XLEN];
        end else if (r_s1_sign) begin
            // Negative side may reach exactly 2^(XLEN-1).
            w_in_range = !w_mag[XLEN] && (!w_mag[XLEN-1] || (w_mag[XLEN-2:0] == '0));
        end else begin
            w_in_range = (w_mag[XLEN:XLEN-1] == 2'b00);
        end

        if (r_s1_nan) begin
            w_s2_int   = w_max;
            w_s2_flags = 5'b10000;
        end else if (r_s1_ovf || !w_in_range) begin
            w_s2_int   = r_s1_sign ? w_min : w_max;
            w_s2_flags = 5'b10000;
        end else begin
            w_s2_int   = r_s1_sign ? -w_mag[XLEN-1:0] : w_mag[XLEN-1:0];
            w_s2_flags = {4'b0000, r_s1_guard || r_s1_sticky};
        end
    end

    logic             r_s2_valid;
    logic [XLEN-1:0]  r_s2_int;
    logic [4:0]       r_s2_flags;
    logic [TAG_W-1:0] r_s2_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_sign     <= 1'b0;
            r_s1_unsigned <= 1'b0;
            r_s1_rm       <= '0;
            r_s1_tag      <= '0;
            r_s1_int      <= '0;
            r_s1_guard    <= 1'b0;
            r_s1_sticky   <= 1'b0;
            r_s1_nan      <= 1'b0;
            r_s1_ovf      <= 1'b0;
            r_s2_valid    <= 1'b0;
            r_s2_int      <= '0;
            r_s2_flags    <= '0;
            r_s2_tag      <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign     <= in_float[31];
                r_s1_unsigned <= in_unsigned;
                r_s1_rm       <= in_rm;
                r_s1_tag      <= in_tag;
                r_s1_int      <= w_s1_int;
                r_s1_guard    <= w_s1_guard;
                r_s1_sticky   <= w_s1_sticky;
                r_s1_nan      <= w_s1_nan;
                r_s1_ovf      <= w_s1_ovf;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_int   <= w_s2_int;
                r_s2_flags <= w_s2_flags;
                r_s2_tag   <= r_s1_tag;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_int   = r_s2_int;
    assign out_flags = r_s2_flags;
    assign out_tag   = r_s2_tag;

endmodule

// File: tb/tb_fp_cvt_f2i_pipe.sv
// Bench for fp_cvt_f2i_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream;
// each keeps its own scoreboard fed by an exact-arithmetic reference conversion.
module tb_fp_cvt_f2i_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [31:0] in_float;
    logic        in_unsigned;
    logic [2:0]  in_rm;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32;
    logic [31:0] out_int32;
    logic [4:0]  out_flags32, out_tag32;
    logic        in_ready64, out_valid64;
    logic [63:0] out_int64;
    logic [4:0]  out_flags64, out_tag64;

    fp_cvt_f2i_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .in_float(in_float), .in_unsigned(in_unsigned), .in_rm(in_rm), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_int(out_int32),
        .out_flags(out_flags32), .out_tag(out_tag32)
    );

    fp_cvt_f2i_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .in_float(in_float), .in_unsigned(in_unsigned), .in_rm(in_rm), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_int(out_int64),
        .out_flags(out_flags64), .out_tag(out_tag64)
    );

    typedef struct {
        logic [63:0] val;
        logic [4:0]  flags;
        logic [4:0]  tag;
    } exp_t;

    exp_t       q32[$];
    exp_t       q64[$];
    int         n_compared   = 0;
    int         n_mismatched = 0;
    logic [4:0] next_tag     = 5'd0;
    bit         last_rdy32;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Exact conversion: value = m * 2^p, rounded by comparing the discarded
    // remainder against one half, then clamped to the target range.
    function automatic void ref_cvt(input logic [31:0] f, input logic uns, input logic [2:0] rm,
                                    input int xlen, output logic [63:0] res,
                                    output logic [4:0] flags);
        logic signed [129:0] lim_hi, lim_lo, mag, v;
        logic [63:0] mask;
        logic [23:0] m;
        int          p, sh;
        longint      q, rem, half;
        logic        up, s;
        s     = f[31];
        mask  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        if (uns) begin
            lim_lo = 0;
            lim_hi = (130'sd1 <<< xlen) - 1;
        end else begin
            lim_lo = -(130'sd1 <<< (xlen - 1));
            lim_hi = (130'sd1 <<< (xlen - 1)) - 1;
        end
        flags = 5'h00;
        if (f[30:23] == 8'hFF) begin
            flags = 5'h10;
            if (f[22:0] != 0 || !s) res = lim_hi[63:0] & mask;
            else                    res = lim_lo[63:0] & mask;
            return;
        end
        m    = {f[30:23] != 8'd0, f[22:0]};
        p    = (f[30:23] == 8'd0) ? -149 : int'(f[30:23]) - 150;
        rem  = 0;
        half = 1;
        up   = 1'b0;
        if (p >= 0) begin
            mag = 130'(m);
            mag = mag <<< p;
        end else begin
            sh   = (-p > 26) ? 26 : -p;
            q    = longint'(m) >> sh;
            rem  = longint'(m) - (q << sh);
            half = longint'(1) << (sh - 1);
            case (rm)
                3'd0:    up = (rem > half) || (rem == half && (q % 2) == 1);
                3'd2:    up = s && rem != 0;
                3'd3:    up = !s && rem != 0;
                3'd4:    up = (rem >= half);
                default: up = 1'b0;
            endcase
            mag = 130'(q + (up ? 64'sd1 : 64'sd0));
        end
        v = s ? -mag : mag;
        if (v > lim_hi) begin
            res   = lim_hi[63:0] & mask;
            flags = 5'h10;
        end else if (v < lim_lo) begin
            res   = lim_lo[63:0] & mask;
            flags = 5'h10;
        end else begin
            res   = v[63:0] & mask;
            flags = (rem != 0) ? 5'h01 : 5'h00;
        end
    endfunction

    function automatic logic [31:0] rand_float();
        logic [7:0]  e;
        logic [22:0] fr;
        case ($urandom_range(0, 7))
            0:       e = 8'($urandom_range(110, 135));
            1:       e = 8'($urandom_range(136, 160));
            2:       e = 8'($urandom_range(155, 195));
            3:       e = 8'hFF;
            4:       e = 8'($urandom_range(0, 2));
            5:       e = 8'($urandom_range(120, 127));
            default: e = 8'($urandom);
        endcase
        fr = 23'($urandom);
        case ($urandom_range(0, 3))
            0:       fr = 23'd0;
            1:       fr = fr & 23'h7F0000;
            default: ;
        endcase
        return {1'($urandom), e, fr};
    endfunction

    task automatic check_outputs();
        if (out_valid32) begin
            if (q32.size() == 0) check_eq("spurious32", 64'd1, 64'd0);
            else begin
                check_eq("int32", 64'(out_int32), q32[0].val);
                check_eq("flags32", 64'(out_flags32), 64'(q32[0].flags));
                check_eq("tag32", 64'(out_tag32), 64'(q32[0].tag));
            end
        end
        if (out_valid64) begin
            if (q64.size() == 0) check_eq("spurious64", 64'd1, 64'd0);
            else begin
                check_eq("int64", out_int64, q64[0].val);
                check_eq("flags64", 64'(out_flags64), 64'(q64[0].flags));
                check_eq("tag64", 64'(out_tag64), 64'(q64[0].tag));
            end
        end
    endtask

    // One clock: drive inputs, book accepts/retires, cross the edge, check outputs.
    task automatic tick(input bit v, input logic [31:0] f, input bit uns, input logic [2:0] rm,
                        input bit ordy);
        exp_t        e;
        logic [63:0] r;
        logic [4:0]  fl;
        in_valid    = v;
        in_float    = f;
        in_unsigned = uns;
        in_rm       = rm;
        in_tag      = next_tag;
        out_ready   = ordy;
        #1;
        last_rdy32 = in_ready32;
        check_eq("in_ready32", 64'(in_ready32), 64'(!out_valid32 || ordy));
        check_eq("in_ready64", 64'(in_ready64), 64'(!out_valid64 || ordy));
        if (v && in_ready32) begin
            ref_cvt(f, uns, rm, 32, r, fl);
            e.val = r; e.flags = fl; e.tag = next_tag;
            q32.push_back(e);
        end
        if (v && in_ready64) begin
            ref_cvt(f, uns, rm, 64, r, fl);
            e.val = r; e.flags = fl; e.tag = next_tag;
            q64.push_back(e);
        end
        if (v && in_ready32) next_tag = next_tag + 5'd1;
        if (out_valid32 && ordy && q32.size() > 0) void'(q32.pop_front());
        if (out_valid64 && ordy && q64.size() > 0) void'(q64.pop_front());
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic directed(input string name, input logic [31:0] f, input bit uns,
                            input logic [2:0] rm, input bit wide, input logic [63:0] exp_val,
                            input logic [4:0] exp_flags);
        int          lat;
        bit          seen;
        logic [63:0] got_val;
        logic [4:0]  got_flags;
        tick(1'b1, f, uns, rm, 1'b1);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 8) begin
            if (wide ? out_valid64 : out_valid32) seen = 1'b1;
            else begin
                tick(1'b0, 32'd0, 1'b0, 3'd0, 1'b1);
                lat++;
            end
        end
        got_val   = wide ? out_int64 : 64'(out_int32);
        got_flags = wide ? out_flags64 : out_flags32;
        check_eq({name, "_lat"}, 64'(lat), 64'd2);
        check_eq({name, "_int"}, got_val, exp_val);
        check_eq({name, "_flags"}, 64'(got_flags), 64'(exp_flags));
        tick(1'b0, 32'd0, 1'b0, 3'd0, 1'b1);
    endtask

    initial begin
        bit v;
        bit r;
        int pct;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_float    = '0;
        in_unsigned = 1'b0;
        in_rm       = '0;
        in_tag      = '0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rst_valid", 64'(out_valid32), 64'd0);
        check_eq("rst_int", 64'(out_int32), 64'd0);
        check_eq("rst_flags", 64'(out_flags32), 64'd0);
        check_eq("rst_tag", 64'(out_tag32), 64'd0);
        check_eq("rst_ready", 64'(in_ready32), 64'd1);
        check_eq("rst_valid64", 64'(out_valid64), 64'd0);

        // Directed vectors with hand-derived results.
        directed("rne_2p5",  32'h40200000, 1'b0, 3'd0, 1'b0, 64'h2, 5'h01);
        directed("rup_2p5",  32'h40200000, 1'b0, 3'd3, 1'b0, 64'h3, 5'h01);
        directed("rmm_m2p5", 32'hC0200000, 1'b0, 3'd4, 1'b0, 64'hFFFFFFFD, 5'h01);
        directed("rtz_0p5",  32'h3F000000, 1'b0, 3'd1, 1'b0, 64'h0, 5'h01);
        directed("rsv_rm",   32'h40200000, 1'b0, 3'd5, 1'b0, 64'h2, 5'h01);
        directed("s_2p31",   32'h4F000000, 1'b0, 3'd0, 1'b0, 64'h7FFFFFFF, 5'h10);
        directed("u_2p31",   32'h4F000000, 1'b1, 3'd0, 1'b0, 64'h80000000, 5'h00);
        directed("s_m2p31",  32'hCF000000, 1'b0, 3'd0, 1'b0, 64'h80000000, 5'h00);
        directed("u_2p32",   32'h4F800000, 1'b1, 3'd0, 1'b0, 64'hFFFFFFFF, 5'h10);
        directed("u_m1",     32'hBF800000, 1'b1, 3'd0, 1'b0, 64'h0, 5'h10);
        directed("u_m0p3",   32'hBE99999A, 1'b1, 3'd1, 1'b0, 64'h0, 5'h01);
        directed("nan",      32'h7FC00000, 1'b0, 3'd0, 1'b0, 64'h7FFFFFFF, 5'h10);
        directed("u_minf",   32'hFF800000, 1'b1, 3'd0, 1'b0, 64'h0, 5'h10);
        directed("denorm",   32'h00000001, 1'b0, 3'd3, 1'b0, 64'h1, 5'h01);
        directed("l_2p63",   32'h5F000000, 1'b1, 3'd0, 1'b1, 64'h8000000000000000, 5'h00);
        directed("l_s2p63",  32'h5F000000, 1'b0, 3'd0, 1'b1, 64'h7FFFFFFFFFFFFFFF, 5'h10);

        // Streaming: 8 back-to-back operations, results on consecutive cycles.
        for (int k = 0; k < 10; k++) begin
            tick(k < 8, rand_float(), 1'($urandom), 3'($urandom), 1'b1);
            check_eq("stream_valid", 64'(out_valid32), 64'(k >= 1 && k <= 8));
        end

        // Back-pressure with both stages full.
        tick(1'b1, rand_float(), 1'b0, 3'd0, 1'b0);
        tick(1'b1, rand_float(), 1'b1, 3'd3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, rand_float(), 1'b0, 3'd2, 1'b0);
            check_eq("bp_in_ready", 64'(last_rdy32), 64'd0);
            check_eq("bp_valid", 64'(out_valid32), 64'd1);
        end
        for (int k = 0; k < 4; k++) tick(1'b0, 32'd0, 1'b0, 3'd0, 1'b1);
        check_eq("bp_drain", 64'(q32.size()), 64'd0);

        // Reset with both stages valid; an operand offered during reset is dropped.
        tick(1'b1, rand_float(), 1'b0, 3'd0, 1'b0);
        tick(1'b1, rand_float(), 1'b0, 3'd0, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_float = 32'h40400000;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        q32.delete();
        q64.delete();
        #1;
        check_eq("mid_rst_valid", 64'(out_valid32), 64'd0);
        check_eq("mid_rst_int", 64'(out_int32), 64'd0);
        check_eq("mid_rst_flags", 64'(out_flags32), 64'd0);
        check_eq("mid_rst_ready", 64'(in_ready32), 64'd1);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 32'd0, 1'b0, 3'd0, 1'b1);
            check_eq("no_stale", 64'(out_valid32), 64'd0);
        end

        // Randomized traffic under varying back-pressure.
        for (int blk = 0; blk < 6; blk++) begin
            pct = (blk % 3 == 0) ? 100 : ((blk % 3 == 1) ? 60 : 25);
            for (int c = 0; c < 300; c++) begin
                v = ($urandom_range(0, 99) < 80);
                r = ($urandom_range(0, 99) < pct);
                tick(v, rand_float(), 1'($urandom), 3'($urandom), r);
            end
        end
        for (int k = 0; k < 8; k++) tick(1'b0, 32'd0, 1'b0, 3'd0, 1'b1);
        check_eq("final_drain32", 64'(q32.size()), 64'd0);
        check_eq("final_drain64", 64'(q64.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
